// File: rtl/h_out_serializer.sv
// h_out_serializer: two-slot hidden-vector buffer streamed out one element per accepted beat
module h_out_serializer #(
  parameter int ELEMENT_BITS = 8,
  parameter int FEATURES = 4,
  parameter int FEATURE_BITS = 3
) (
  input  logic                             sys_clk,
  input  logic                             reset,
  input  logic                             h_load,
  input  logic [FEATURES*ELEMENT_BITS-1:0] h_par,
  output logic                             load_ready,
  input  logic                             start_read,
  input  logic                             ser_ready,
  output logic                             ser_valid,
  output logic [ELEMENT_BITS-1:0]          ser_data,
  output logic [FEATURE_BITS-1:0]          hidden_address,
  output logic                             done,
  output logic                             overflow
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state, state_nx;
  logic [FEATURES*ELEMENT_BITS-1:0] slots [2];
  logic [FEATURE_BITS-1:0] addr;
  logic [1:0] count;
  logic wr_ptr, rd_ptr, do_load, last;
  assign load_ready = count < 2'd2;
  assign do_load = h_load && load_ready;
  assign last = state == SEND && ser_ready && addr == FEATURE_BITS'(FEATURES-1);
  assign ser_valid = state == SEND;
  assign ser_data = ser_valid ? slots[rd_ptr][addr*ELEMENT_BITS +: ELEMENT_BITS] : '0;
  assign hidden_address = ser_valid ? addr : '0;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && start_read && count != 2'd0) ? SEND :
               last ? DONE :
               (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge sys_clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge sys_clk)
    if (reset) begin
      count <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      addr <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count + 2'(do_load) - 2'(last);
      if (do_load) wr_ptr <= ~wr_ptr;
      if (last) rd_ptr <= ~rd_ptr;
      if (h_load && !load_ready) overflow <= 1'b1;
      if (state == SEND && ser_ready) addr <= last ? '0 : addr + 1'b1;
    end
  always_ff @(posedge sys_clk)
    if (do_load) slots[wr_ptr] <= h_par;
endmodule

// File: tb/tb_h_out_serializer.sv
// tb_h_out_serializer: directed self-checking bench for h_out_serializer
module tb_h_out_serializer;
  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  logic h_load = 1'b0;
  logic [31:0] h_par = '0;
  logic load_ready;
  logic start_read = 1'b0;
  logic ser_ready = 1'b0;
  logic ser_valid;
  logic [7:0] ser_data;
  logic [2:0] hidden_address;
  logic done;
  logic overflow;
  int checks = 0;
  int errors = 0;
  h_out_serializer #(.ELEMENT_BITS(8), .FEATURES(4), .FEATURE_BITS(3)) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .h_load(h_load),
    .h_par(h_par),
    .load_ready(load_ready),
    .start_read(start_read),
    .ser_ready(ser_ready),
    .ser_valid(ser_valid),
    .ser_data(ser_data),
    .hidden_address(hidden_address),
    .done(done),
    .overflow(overflow)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_el(input string tag, input logic [31:0] vec, input int k);
    logic [31:0] v;
    v = vec >> (8 * k);
    chk({tag, " valid"}, 32'(ser_valid), 32'd1);
    chk({tag, " data"}, 32'(ser_data), 32'(v[7:0]));
    chk({tag, " addr"}, 32'(hidden_address), 32'(k));
  endtask
  task automatic stream(input string tag, input logic [31:0] vec);
    for (int k = 0; k < 4; k++) begin
      chk_el(tag, vec, k);
      tick();
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " done valid"}, 32'(ser_valid), 32'd0);
    chk({tag, " done data"}, 32'(ser_data), 32'd0);
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst valid", 32'(ser_valid), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst load_ready", 32'(load_ready), 32'd1);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst data", 32'(ser_data), 32'd0);
    chk("rst addr", 32'(hidden_address), 32'd0);
    h_load = 1'b1;
    h_par = 32'h04030201;
    tick();
    h_load = 1'b0;
    start_read = 1'b1;
    ser_ready = 1'b1;
    tick();
    start_read = 1'b0;
    stream("basic", 32'h04030201);
    tick();
    chk("basic done once", 32'(done), 32'd0);
    chk("basic empty", 32'(load_ready), 32'd1);
    tick();
    chk("basic no restart", 32'(ser_valid), 32'd0);
    h_load = 1'b1;
    h_par = 32'h44332211;
    tick();
    h_load = 1'b0;
    start_read = 1'b1;
    ser_ready = 1'b0;
    tick();
    start_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_el("stall pre", 32'h44332211, k);
      tick();
      chk_el("stall hold", 32'h44332211, k);
      ser_ready = 1'b1;
      tick();
      ser_ready = 1'b0;
    end
    chk("stall done", 32'(done), 32'd1);
    tick();
    chk("stall done once", 32'(done), 32'd0);
    h_load = 1'b1;
    h_par = 32'hA4A3A2A1;
    tick();
    chk("fill1 ready", 32'(load_ready), 32'd1);
    h_par = 32'hB4B3B2B1;
    tick();
    chk("fill2 ready", 32'(load_ready), 32'd0);
    chk("fill2 overflow", 32'(overflow), 32'd0);
    h_par = 32'hC4C3C2C1;
    tick();
    h_load = 1'b0;
    chk("fill3 overflow", 32'(overflow), 32'd1);
    start_read = 1'b1;
    ser_ready = 1'b1;
    tick();
    stream("order A", 32'hA4A3A2A1);
    tick();
    chk("order gap", 32'(ser_valid), 32'd0);
    tick();
    start_read = 1'b0;
    stream("order B", 32'hB4B3B2B1);
    tick();
    chk("order sticky", 32'(overflow), 32'd1);
    h_load = 1'b1;
    h_par = 32'hA4A3A2A1;
    tick();
    h_par = 32'hB4B3B2B1;
    tick();
    h_load = 1'b0;
    start_read = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk_el("race A", 32'hA4A3A2A1, k);
      tick();
    end
    chk_el("race A", 32'hA4A3A2A1, 3);
    chk("race ready", 32'(load_ready), 32'd0);
    h_load = 1'b1;
    h_par = 32'hC4C3C2C1;
    tick();
    h_load = 1'b0;
    chk("race done", 32'(done), 32'd1);
    chk("race overflow", 32'(overflow), 32'd1);
    chk("race count1", 32'(load_ready), 32'd1);
    tick();
    tick();
    stream("race B", 32'hB4B3B2B1);
    tick();
    tick();
    chk("race C dropped", 32'(ser_valid), 32'd0);
    tick();
    chk("race C dropped2", 32'(ser_valid), 32'd0);
    reset = 1'b1;
    start_read = 1'b0;
    tick();
    reset = 1'b0;
    start_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wait empty", 32'(ser_valid), 32'd0);
    end
    h_load = 1'b1;
    h_par = 32'h0D0C0B0A;
    tick();
    h_load = 1'b0;
    chk("late load edge", 32'(ser_valid), 32'd0);
    tick();
    start_read = 1'b0;
    chk_el("late", 32'h0D0C0B0A, 0);
    ser_ready = 1'b0;
    h_load = 1'b1;
    h_par = 32'hEEEEEEEE;
    tick();
    h_load = 1'b0;
    chk_el("no corrupt", 32'h0D0C0B0A, 0);
    ser_ready = 1'b1;
    tick();
    for (int k = 1; k < 4; k++) begin
      chk_el("late", 32'h0D0C0B0A, k);
      tick();
    end
    chk("late done", 32'(done), 32'd1);
    tick();
    h_load = 1'b1;
    h_par = 32'h33333333;
    tick();
    h_par = 32'h55555555;
    tick();
    h_load = 1'b0;
    chk("pre-rst overflow", 32'(overflow), 32'd1);
    start_read = 1'b1;
    tick();
    tick();
    tick();
    chk_el("mid", 32'hEEEEEEEE, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_read = 1'b0;
    chk("mid rst valid", 32'(ser_valid), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst ready", 32'(load_ready), 32'd1);
    chk("mid rst overflow", 32'(overflow), 32'd0);
    tick();
    chk("mid rst no done", 32'(done), 32'd0);
    start_read = 1'b1;
    tick();
    tick();
    chk("mid rst empty", 32'(ser_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/h_out_serializer.md
H_OUT_SERIALIZER -- requirements
Module: h_out_serializer

Interface
REQ-001 Parameter ELEMENT_BITS, default 8, bit width of one hidden-state element.
REQ-002 Parameter FEATURES, default 4, number of elements in one hidden vector.
REQ-003 Parameter FEATURE_BITS, default 3, width of hidden_address; SHALL satisfy 2**FEATURE_BITS >= FEATURES.
REQ-004 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 h_load  input  1  one-cycle pulse: capture h_par into a free buffer slot.
REQ-007 h_par  input  FEATURES*ELEMENT_BITS  hidden vector; element k is h_par[(k+1)*ELEMENT_BITS-1 : k*ELEMENT_BITS].
REQ-008 load_ready  output  1  high when at least one buffer slot is free.
REQ-009 start_read  input  1  level request to stream one buffered vector, driven high while op_mode is R_OUT.
REQ-010 ser_ready  input  1  downstream accepts ser_data this cycle.
REQ-011 ser_valid  output  1  ser_data holds a valid element.
REQ-012 ser_data  output  ELEMENT_BITS  current serial element.
REQ-013 hidden_address  output  FEATURE_BITS  index of the element on ser_data.
REQ-014 done  output  1  one-cycle pulse after the last element of a vector is accepted.
REQ-015 overflow  output  1  sticky error flag for a load request that was dropped.

Function
REQ-016 Buffer: two slots of FEATURES*ELEMENT_BITS, with a write pointer, a read pointer and a count (0..2); load_ready SHALL equal (count < 2).
REQ-017 h_load with load_ready=1 SHALL write h_par into the slot at the write pointer, toggle the write pointer and increment count.
REQ-018 h_load with load_ready=0 SHALL be dropped, leave the buffer unchanged and set overflow to 1 until reset.
REQ-019 FSM states are IDLE, SEND and DONE.
REQ-020 IDLE -> SEND when start_read=1 and count>0, with hidden_address set to 0.
REQ-021 In IDLE, if start_read=1 and count=0, the FSM SHALL stay in IDLE and wait, with no timeout.
REQ-022 In SEND, ser_valid=1 and ser_data = element hidden_address of the slot at the read pointer.
REQ-023 While ser_valid=1 and ser_ready=0, ser_data and hidden_address SHALL hold stable.
REQ-024 In SEND, on ser_ready=1 with hidden_address < FEATURES-1, hidden_address SHALL increment by 1.
REQ-025 In SEND, on ser_ready=1 with hidden_address = FEATURES-1, the FSM SHALL go to DONE; the read slot is freed, the read pointer toggles and count decrements.
REQ-026 In DONE, done=1 and ser_valid=0 for exactly one cycle, then the FSM goes to IDLE.
REQ-027 When ser_valid=0, ser_data and hidden_address SHALL read 0.
REQ-028 Latency: start_read sampled high in IDLE with count>0 at edge t gives ser_valid=1 in the cycle after t.
REQ-029 One vector takes at least FEATURES+2 cycles from start_read to the next possible IDLE exit.
REQ-030 If a slot is freed and h_load arrives in the same cycle with count=2, the load SHALL be dropped, because load_ready is evaluated on pre-edge count; overflow is set.
REQ-031 If a slot is freed and h_load arrives in the same cycle with count<2, both take effect and count is unchanged net.
REQ-032 A load into the free slot SHALL never corrupt the slot currently being streamed.
REQ-033 Deasserting start_read mid-SEND SHALL NOT abort streaming; the vector always completes.

Reset
REQ-034 reset=1 at a clock edge SHALL force: FSM IDLE, count 0, both pointers 0, hidden_address 0, ser_valid 0, ser_data 0, done 0, overflow 0, load_ready 1.
REQ-035 Buffer contents need not be cleared by reset.
REQ-036 Reset asserted mid-SEND SHALL abandon the vector, with no done pulse.
REQ-037 reset has priority over h_load and start_read in the same cycle.

Verification
REQ-038 Load h_par=0x04030201 (FEATURES=4), start_read=1, ser_ready=1 -> ser_data 01,02,03,04 with hidden_address 0..3 on consecutive cycles, then done pulse, count 0.
REQ-039 Same stimulus with ser_ready low on alternate cycles -> each element held until accepted, no element skipped or duplicated, one done pulse.
REQ-040 Three h_load pulses with no reads -> load_ready=0 after the second, overflow=1 after the third, first two vectors stream intact in load order.
REQ-041 start_read=1 with an empty buffer for 10 cycles, then h_load -> ser_valid rises in the cycle after the load plus one, element 0 correct.
REQ-042 Buffer full, h_load in the same cycle as the last accept -> load dropped, overflow=1, count=1.
REQ-043 Reset asserted during element 2 of a vector -> next cycle ser_valid=0, done=0, load_ready=1, overflow=0.
